// File: rtl/max_window_packer_pkg.sv
// Shared constants and types for the max-pool window packer.
package max_window_packer_pkg;

  localparam int unsigned DATA_WIDTH   = 16;
  localparam int unsigned SIZE         = 9;
  localparam int unsigned N            = SIZE * SIZE;
  localparam logic [15:0] FP16_NEG_INF = 16'hFC00;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_e;

endpackage

// File: rtl/max_window_packer_window_bank.sv
// One N-slot window register bank with per-slot write, commit, discard and release.
module window_bank
  import max_window_packer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned N          = 81,
  parameter int unsigned IDX_W      = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear_i,
  input  logic                    wr_en_i,
  input  logic [IDX_W-1:0]        wr_idx_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic                    commit_i,
  input  logic                    discard_i,
  input  logic                    release_i,
  output bank_state_e             state_o,
  output logic [DATA_WIDTH*N-1:0] data_o
);

  logic [DATA_WIDTH-1:0] slot_q [N];
  bank_state_e           state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < N; k++) slot_q[k] <= '0;
    end else if (wr_en_i) begin
      slot_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Clear (flush) only returns the bank to EMPTY; slot contents are kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else if (clear_i || release_i) begin
      state_q <= EMPTY;
    end else if (commit_i) begin
      state_q <= FULL;
    end else if (discard_i) begin
      state_q <= EMPTY;
    end else if (wr_en_i) begin
      state_q <= FILLING;
    end
  end

  always_comb begin
    data_o = '0;
    for (int unsigned k = 0; k < N; k++) data_o[k*DATA_WIDTH +: DATA_WIDTH] = slot_q[k];
  end

  assign state_o = state_q;

endmodule

// File: rtl/max_window_packer.sv
// Packs a row-major FP16 element stream into SIZE x SIZE windows via two ping-pong banks.
module max_window_packer
  import max_window_packer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = max_window_packer_pkg::DATA_WIDTH,
  parameter int unsigned SIZE       = max_window_packer_pkg::SIZE
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [DATA_WIDTH-1:0]             s_data,
  input  logic                              s_last,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [DATA_WIDTH*SIZE*SIZE-1:0]   m_window,
  output logic                              err_len
);

  localparam int unsigned NW    = SIZE * SIZE;
  localparam int unsigned IDX_W = $clog2(NW);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             err_len_q, err_len_d;

  bank_state_e                bank_state [2];
  logic [DATA_WIDTH*NW-1:0]   bank_data  [2];

  logic accept, last_slot, commit, discard, consume;

  assign s_ready   = (bank_state[wr_ptr_q] != FULL);
  assign m_valid   = (bank_state[rd_ptr_q] == FULL);
  assign m_window  = bank_data[rd_ptr_q];
  assign err_len   = err_len_q;

  assign accept    = s_valid && s_ready && !flush;
  assign last_slot = (idx_q == IDX_W'(NW - 1));
  assign commit    = accept && last_slot;
  assign discard   = accept && s_last && !last_slot;
  assign consume   = m_valid && m_ready && !flush;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic sel_wr, sel_rd;
    assign sel_wr = (wr_ptr_q == 1'(b));
    assign sel_rd = (rd_ptr_q == 1'(b));

    window_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .N          (NW),
      .IDX_W      (IDX_W)
    ) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (flush),
      .wr_en_i   (accept && sel_wr),
      .wr_idx_i  (idx_q),
      .wr_data_i (s_data),
      .commit_i  (commit && sel_wr),
      .discard_i (discard && sel_wr),
      .release_i (consume && sel_rd),
      .state_o   (bank_state[b]),
      .data_o    (bank_data[b])
    );
  end

  // Flush realigns both pointers so the next committed bank is the one read.
  always_comb begin
    idx_d     = idx_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    err_len_d = 1'b0;
    if (flush) begin
      idx_d    = '0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (accept) begin
        err_len_d = s_last ^ last_slot;
        if (commit || discard) idx_d = '0;
        else                   idx_d = idx_q + 1'b1;
      end
      if (commit)  wr_ptr_d = ~wr_ptr_q;
      if (consume) rd_ptr_d = ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      err_len_q <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      err_len_q <= err_len_d;
    end
  end

endmodule

// File: tb/tb_max_window_packer.sv
// Directed bench for max_window_packer: single window, backpressure, length errors, flush, reset.
module tb_max_window_packer;

  localparam int W  = 16;
  localparam int N  = 81;
  localparam int WB = W * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [W-1:0]  s_data = '0;
  logic          s_last = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [WB-1:0] m_window;
  logic          err_len;

  int errors = 0;
  int checks = 0;

  max_window_packer #(.DATA_WIDTH(16), .SIZE(9)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_window (m_window),
    .err_len  (err_len)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] elem(input int w, input int i);
    return 16'(32'h1000 + w * 256 + i);
  endfunction

  function automatic logic [WB-1:0] win(input int w);
    logic [WB-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = elem(w, i);
    return v;
  endfunction

  // Reference FP16 max over all slots using a sign-magnitude ordering key.
  function automatic logic [W-1:0] fp16_max(input logic [WB-1:0] v);
    logic [W-1:0] best, x, kb, kx;
    best = v[W-1:0];
    for (int i = 1; i < N; i++) begin
      x  = v[i*W +: W];
      kb = best[15] ? ~best : (best | 16'h8000);
      kx = x[15]    ? ~x    : (x    | 16'h8000);
      if (kx > kb) best = x;
    end
    return best;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic last);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!s_ready && n < 200) begin
      step();
      n++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: s_ready=%0b required 1", s_ready);
    end
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_window(input int w, input logic with_last);
    for (int i = 0; i < N; i++) send(elem(w, i), with_last && (i == N - 1));
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || err_len !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: m_valid=%0b s_ready=%0b err_len=%0b required 0 1 0", m_valid, s_ready, err_len);
    end
    checks++;
    if (m_window !== '0) begin
      errors++;
      $display("FAIL reset_window: m_window[15:0]=%h required all zero", m_window[15:0]);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_window();
    logic [WB-1:0] exp;
    for (int i = 0; i < N; i++) exp[i*W +: W] = (i == 40) ? 16'h4500 : 16'h4000;
    m_ready = 1'b0;
    for (int i = 0; i < N - 1; i++) send(exp[i*W +: W], 1'b0);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early_valid: m_valid=%0b required 0", m_valid);
    end
    send(16'h4000, 1'b1);
    checks++;
    if (m_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: m_valid=%0b required 1", m_valid);
    end
    checks++;
    if (m_window[655:640] !== 16'h4500 || m_window !== exp) begin
      errors++;
      $display("FAIL single_data: slot40=%h slot0=%h required 4500 4000", m_window[655:640], m_window[15:0]);
    end
    checks++;
    if (fp16_max(m_window) !== 16'h4500) begin
      errors++;
      $display("FAIL single_max: max=%h required 4500", fp16_max(m_window));
    end
    m_ready = 1'b1;
    step();
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_consume: m_valid=%0b s_ready=%0b required 0 1", m_valid, s_ready);
    end
  endtask

  task automatic test_backpressure();
    int acc, out, cyc;
    logic will_acc;
    m_ready = 1'b0;
    send_window(0, 1'b1);
    send_window(1, 1'b1);
    s_valid = 1'b1;
    s_data  = elem(2, 0);
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready_low: s_ready=%0b required 0", s_ready);
    end
    repeat (3) step();
    checks++;
    if (m_valid !== 1'b1 || m_window !== win(0) || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold: m_valid=%0b slot0=%h s_ready=%0b required 1 %h 0", m_valid, m_window[15:0], s_ready, elem(0, 0));
    end
    m_ready = 1'b1;
    acc = 162;
    out = 0;
    cyc = 0;
    while ((acc < 243 || out < 3) && cyc < 1000) begin
      s_valid  = (acc < 243);
      s_data   = elem(2, acc - 162);
      s_last   = (acc - 162 == N - 1);
      will_acc = s_valid && s_ready;
      if (m_valid) begin
        checks++;
        if (out > 2 || m_window !== win(out)) begin
          errors++;
          $display("FAIL bp_order: window %0d slot0=%h required %h", out, m_window[15:0], elem(out, 0));
        end
        out++;
      end
      step();
      if (will_acc) acc++;
      cyc++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    checks++;
    if (acc != 243 || out != 3) begin
      errors++;
      $display("FAIL bp_count: accepted=%0d windows=%0d required 243 3", acc, out);
    end
  endtask

  task automatic test_back_to_back();
    int lows, outs;
    m_ready = 1'b0;
    send_window(3, 1'b1);
    for (int i = 0; i < N - 1; i++) send(elem(4, i), 1'b0);
    s_valid = 1'b1;
    s_data  = elem(4, N - 1);
    s_last  = 1'b1;
    m_ready = 1'b1;
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b1 || m_window !== win(3)) begin
      errors++;
      $display("FAIL b2b_pre: s_ready=%0b m_valid=%0b slot0=%h required 1 1 %h", s_ready, m_valid, m_window[15:0], elem(3, 0));
    end
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b1 || m_window !== win(4)) begin
      errors++;
      $display("FAIL b2b_simul: s_ready=%0b m_valid=%0b slot0=%h required 1 1 %h", s_ready, m_valid, m_window[15:0], elem(4, 0));
    end
    step();
    lows = 0;
    outs = 0;
    for (int w = 5; w < 7; w++) begin
      for (int i = 0; i < N; i++) begin
        s_valid = 1'b1;
        s_data  = elem(w, i);
        s_last  = (i == N - 1);
        if (!s_ready) lows++;
        if (m_valid) outs++;
        step();
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (m_valid) outs++;
    checks++;
    if (lows != 0 || outs != 2 || m_window !== win(6)) begin
      errors++;
      $display("FAIL b2b_stream: ready_low=%0d windows=%0d last_slot0=%h required 0 2 %h", lows, outs, m_window[15:0], elem(6, 0));
    end
    step();
  endtask

  task automatic test_short_window();
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(elem(7, i), 1'b0);
    checks++;
    if (err_len !== 1'b0) begin
      errors++;
      $display("FAIL short_early_err: err_len=%0b required 0", err_len);
    end
    send(elem(7, 10), 1'b1);
    checks++;
    if (err_len !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL short_pulse: err_len=%0b m_valid=%0b required 1 0", err_len, m_valid);
    end
    step();
    checks++;
    if (err_len !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL short_after: err_len=%0b m_valid=%0b required 0 0", err_len, m_valid);
    end
    m_ready = 1'b0;
    send_window(8, 1'b1);
    checks++;
    if (m_valid !== 1'b1 || m_window[15:0] !== elem(8, 0) || m_window !== win(8)) begin
      errors++;
      $display("FAIL short_recover: m_valid=%0b slot0=%h required 1 %h", m_valid, m_window[15:0], elem(8, 0));
    end
    m_ready = 1'b1;
    step();
  endtask

  task automatic test_missing_last();
    m_ready = 1'b0;
    send_window(9, 1'b0);
    checks++;
    if (err_len !== 1'b1 || m_valid !== 1'b1 || m_window !== win(9)) begin
      errors++;
      $display("FAIL nolast: err_len=%0b m_valid=%0b slot80=%h required 1 1 %h", err_len, m_valid, m_window[WB-1 -: W], elem(9, 80));
    end
    m_ready = 1'b1;
    step();
    checks++;
    if (err_len !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL nolast_after: err_len=%0b m_valid=%0b required 0 0", err_len, m_valid);
    end
  endtask

  task automatic test_flush();
    m_ready = 1'b0;
    send_window(10, 1'b1);
    for (int i = 0; i < 30; i++) send(elem(11, i), 1'b0);
    flush   = 1'b1;
    s_valid = 1'b1;
    s_data  = elem(11, 30);
    m_ready = 1'b1;
    step();
    flush   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || err_len !== 1'b0) begin
      errors++;
      $display("FAIL flush_state: m_valid=%0b s_ready=%0b err_len=%0b required 0 1 0", m_valid, s_ready, err_len);
    end
    send_window(12, 1'b1);
    checks++;
    if (m_valid !== 1'b1 || m_window !== win(12)) begin
      errors++;
      $display("FAIL flush_fresh: m_valid=%0b slot0=%h required 1 %h", m_valid, m_window[15:0], elem(12, 0));
    end
    m_ready = 1'b1;
    step();
  endtask

  task automatic test_async_reset();
    m_ready = 1'b0;
    send_window(13, 1'b1);
    for (int i = 0; i < 30; i++) send(elem(14, i), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (m_window !== '0 || m_valid !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL arst_now: slot0=%h m_valid=%0b s_ready=%0b required 0000 0 1", m_window[15:0], m_valid, s_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    send_window(15, 1'b1);
    checks++;
    if (m_valid !== 1'b1 || m_window !== win(15)) begin
      errors++;
      $display("FAIL arst_fresh: m_valid=%0b slot0=%h required 1 %h", m_valid, m_window[15:0], elem(15, 0));
    end
    m_ready = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_single_window();
    test_backpressure();
    test_back_to_back();
    test_short_window();
    test_missing_last();
    test_flush();
    test_async_reset();
    do_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
